// File: rtl/int_req_ctrl_pkg.sv
// rtl/int_req_ctrl_pkg.sv - shared constants, state encoding and helpers for int_req_ctrl
package int_pkg;

    localparam int          NSRC     = 4;
    localparam logic [31:0] VEC_BASE = 32'h0000_01F0;
    localparam int          LOST_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } state_t;

    // One-hot decode of a 2-bit source index
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/int_req_ctrl_if.sv
// rtl/int_req_ctrl_if.sv - accelerator/CPU interrupt signal bundle for int_req_ctrl
interface int_req_ctrl_if;

    logic [3:0]  done_pulse;
    logic        int_ack;
    logic        eoi;
    logic [3:0]  irq;
    logic [31:0] vec_addr;
    logic [3:0]  pending;
    logic        busy;
    logic [1:0]  srv_id;
    logic [31:0] lost_cnt;

    modport slave (
        input  done_pulse, int_ack, eoi,
        output irq, vec_addr, pending, busy, srv_id, lost_cnt
    );

    modport master (
        output done_pulse, int_ack, eoi,
        input  irq, vec_addr, pending, busy, srv_id, lost_cnt
    );

endinterface

// File: rtl/int_req_ctrl_prio_enc4.sv
// rtl/int_req_ctrl_prio_enc4.sv - 4-input priority encoder, lowest index wins
module prio_enc4 (
    input  logic [3:0] req,
    output logic       valid,
    output logic [1:0] idx
);

    // Lowest set bit has highest priority
    always_comb begin
        valid = |req;
        idx   = 2'd0;
        casez (req)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

endmodule

// File: rtl/int_req_ctrl.sv
// rtl/int_req_ctrl.sv - interrupt request controller; INT_LOST_CNT_EN enables lost-event counters
module int_req_ctrl #(
    parameter int          NSRC     = 4,
    parameter logic [31:0] VEC_BASE = 32'h0000_01F0
) (
    input  logic            Clk,
    input  logic            reset,
    int_req_ctrl_if.slave   bus
);
    import int_pkg::*;

    state_t            state;
    logic [NSRC-1:0]   pending_q;
    logic [1:0]        srv_id_q;
    logic              enc_valid;
    logic [1:0]        enc_idx;
    logic              do_ack;
    logic [3:0]        ack_mask;
    logic              any_evt;

    prio_enc4 u_prio (
        .req   (pending_q),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

    // An acknowledge only counts while a source is being presented
    assign do_ack   = (state == REQ) && bus.int_ack && enc_valid;
    assign ack_mask = do_ack ? onehot4(enc_idx) : 4'b0000;
    assign any_evt  = |(pending_q | bus.done_pulse);

    // Pending latch and IDLE/REQ/SERV sequencing; a new pulse wins over a coincident ack clear
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pending_q <= '0;
            srv_id_q  <= 2'd0;
        end else begin
            pending_q <= (pending_q & ~ack_mask) | bus.done_pulse;
            case (state)
                IDLE: if (any_evt) state <= REQ;
                REQ: begin
                    if (do_ack) begin
                        srv_id_q <= enc_idx;
                        state    <= SERV;
                    end
                end
                SERV: begin
                    if (bus.eoi) state <= any_evt ? REQ : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.irq      = ((state == REQ) && enc_valid) ? onehot4(enc_idx) : 4'b0000;
    assign bus.vec_addr = (|bus.irq) ? (VEC_BASE + {28'd0, enc_idx, 2'b00}) : VEC_BASE;
    assign bus.pending  = pending_q;
    assign bus.busy     = (state == SERV);
    assign bus.srv_id   = srv_id_q;

`ifdef INT_LOST_CNT_EN
    logic [3:0]        lost_evt;
    logic [LOST_W-1:0] lost_q [4];

    assign lost_evt = bus.done_pulse & pending_q & ~ack_mask;

    // Saturating per-source count of pulses dropped onto an already pending source
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) lost_q[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (lost_evt[i] && (lost_q[i] != {LOST_W{1'b1}}))
                    lost_q[i] <= lost_q[i] + 1'b1;
            end
        end
    end

    assign bus.lost_cnt = {lost_q[3], lost_q[2], lost_q[1], lost_q[0]};
`else
    assign bus.lost_cnt = 32'd0;
`endif

endmodule
